// File: rtl/clock_enable_bank_pkg.sv
// -----------------------------------------------------------------------------
// clock_enable_bank_pkg
// Shared definitions for the clock-enable bank:
//   MAX_CHANNELS_C      - largest bank size supported by the channel decode
//   MAX_COUNTER_WIDTH_C - widest divider/phase/counter a channel can hold
//   ch_width_f()        - channel-index width for a given bank size, min 1
//   CH_WIDTH_C          - channel-index width of a maximum-size bank
//   ch_cfg_t            - one channel configuration (divider, phase)
// -----------------------------------------------------------------------------
package clock_enable_bank_pkg;

   localparam int MAX_CHANNELS_C      = 32;
   localparam int MAX_COUNTER_WIDTH_C = 32;

   // A single-channel bank still needs a 1-bit index port.
   function automatic int ch_width_f(input int nr_channels);
      return (nr_channels > 1) ? $clog2(nr_channels) : 1;
   endfunction

   localparam int CH_WIDTH_C = ch_width_f(MAX_CHANNELS_C);

   // Fields are held at the maximum width; narrower banks zero-extend into
   // them, so comparisons on the full field are exact for any counter width.
   typedef struct packed {
      logic [MAX_COUNTER_WIDTH_C-1:0] divider;
      logic [MAX_COUNTER_WIDTH_C-1:0] phase;
   } ch_cfg_t;

endpackage

// File: rtl/clock_enable_bank_channel.sv
// -----------------------------------------------------------------------------
// clock_enable_channel
// One divider channel: active config, shadow config, pending flag, counter
// and a registered one-cycle enable pulse.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   i_wr       - accepted configuration write for this channel
//   i_divider  - new period in clk cycles, 0 = idle
//   i_phase    - counter start value used at a sync restart
//   i_sync     - realign request shared by all channels
//   o_pending  - shadow config waiting for the next wrap
//   o_enable   - registered enable pulse
// COUNTER_WIDTH_P must not exceed MAX_COUNTER_WIDTH_C.
// -----------------------------------------------------------------------------
module clock_enable_channel
   import clock_enable_bank_pkg::*;
#(
   parameter int COUNTER_WIDTH_P = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_wr,
   input  logic [COUNTER_WIDTH_P-1:0] i_divider,
   input  logic [COUNTER_WIDTH_P-1:0] i_phase,
   input  logic                       i_sync,
   output logic                       o_pending,
   output logic                       o_enable
);

   ch_cfg_t                    r_active;
   ch_cfg_t                    r_shadow;
   logic                       r_pending;
   logic                       r_enable;
   logic [COUNTER_WIDTH_P-1:0] r_cnt;

   ch_cfg_t                    w_cfg_in;
   ch_cfg_t                    w_sync_cfg;
   logic                       w_idle;
   logic                       w_wrap;

   always_comb begin
      w_cfg_in.divider = MAX_COUNTER_WIDTH_C'(i_divider);
      w_cfg_in.phase   = MAX_COUNTER_WIDTH_C'(i_phase);
   end

   // Config in force after a restart: a write on the restart edge is newest,
   // then any pending shadow, otherwise the current active config.
   always_comb begin
      w_sync_cfg = r_active;
      if (i_wr) begin
         w_sync_cfg = w_cfg_in;
      end else if (r_pending) begin
         w_sync_cfg = r_shadow;
      end
   end

   assign w_idle = (r_active.divider == '0);
   // Compared at full field width; divider > 0 here, so D-1 cannot underflow
   // and the counter never needs to hold D itself.
   assign w_wrap = !w_idle &&
                   (MAX_COUNTER_WIDTH_C'(r_cnt) >= (r_active.divider - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active  <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_enable  <= 1'b0;
         r_cnt     <= '0;
      end else if (i_sync) begin
         r_active  <= w_sync_cfg;
         r_pending <= 1'b0;
         r_enable  <= 1'b0;
         // An out-of-range phase (including any phase on an idle channel)
         // restarts from zero.
         r_cnt     <= (w_sync_cfg.phase < w_sync_cfg.divider) ?
                      w_sync_cfg.phase[COUNTER_WIDTH_P-1:0] : '0;
      end else if (w_idle) begin
         // Idle channels take a write immediately; no period is in flight.
         r_enable <= 1'b0;
         r_cnt    <= '0;
         if (i_wr) begin
            r_active <= w_cfg_in;
         end
      end else begin
         if (i_wr) begin
            r_shadow  <= w_cfg_in;
            r_pending <= 1'b1;
         end
         if (w_wrap) begin
            r_enable <= 1'b1;
            r_cnt    <= '0;
            // Only a shadow written before this edge is applied, so the
            // period that is finishing now is never shortened.
            if (r_pending) begin
               r_active  <= r_shadow;
               r_pending <= 1'b0;
            end
         end else begin
            r_enable <= 1'b0;
            r_cnt    <= r_cnt + COUNTER_WIDTH_P'(1);
         end
      end
   end

   assign o_pending = r_pending;
   assign o_enable  = r_enable;

endmodule

// File: rtl/clock_enable_bank.sv
// -----------------------------------------------------------------------------
// clock_enable_bank
// Bank of independent clock-enable dividers sharing one configuration port
// and one realign strobe.
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   cfg_valid    - configuration write request
//   cfg_ready    - write can be accepted (low while target channel pending)
//   cfg_channel  - target channel; indices beyond the bank are accepted and
//                  dropped
//   cfg_divider  - new period in clk cycles, 0 = idle
//   cfg_phase    - counter start value used at sync restart
//   sync_restart - single-cycle realign of all channels
//   enable       - one registered enable pulse per channel
// -----------------------------------------------------------------------------
module clock_enable_bank
   import clock_enable_bank_pkg::ch_width_f;
#(
   parameter  int NR_OF_CHANNELS_P = 4,
   parameter  int COUNTER_WIDTH_P  = 16,
   localparam int CH_WIDTH_C       = ch_width_f(NR_OF_CHANNELS_P)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [CH_WIDTH_C-1:0]       cfg_channel,
   input  logic [COUNTER_WIDTH_P-1:0]  cfg_divider,
   input  logic [COUNTER_WIDTH_P-1:0]  cfg_phase,
   input  logic                        sync_restart,
   output logic [NR_OF_CHANNELS_P-1:0] enable
);

   logic [NR_OF_CHANNELS_P-1:0] w_sel;
   logic [NR_OF_CHANNELS_P-1:0] w_pending;
   logic [NR_OF_CHANNELS_P-1:0] w_wr;

   // One-hot decode instead of indexing pending[] by cfg_channel: an index
   // past the bank selects nothing, so it reads as ready and writes nowhere.
   generate
      for (genvar gi = 0; gi < NR_OF_CHANNELS_P; gi++) begin : g_ch
         assign w_sel[gi] = (cfg_channel == CH_WIDTH_C'(gi));
         assign w_wr[gi]  = cfg_valid & w_sel[gi] & ~w_pending[gi];

         clock_enable_channel #(
            .COUNTER_WIDTH_P (COUNTER_WIDTH_P)
         ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr[gi]),
            .i_divider (cfg_divider),
            .i_phase   (cfg_phase),
            .i_sync    (sync_restart),
            .o_pending (w_pending[gi]),
            .o_enable  (enable[gi])
         );
      end
   endgenerate

   assign cfg_ready = ~|(w_sel & w_pending);

endmodule

// File: tb/tb_clock_enable_bank.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_bank
// Directed stimulus for a 3-channel, 8-bit bank. Every expected enable pulse
// is queued (cycle, vector) when its write or restart is issued; a monitor
// compares the enable bus against the queue head on every falling edge.
// -----------------------------------------------------------------------------
module tb_clock_enable_bank;

   localparam int NR  = 3;
   localparam int W   = 8;
   localparam int CHW = 2;

   logic           clk;
   logic           rst_n;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_channel;
   logic [W-1:0]   cfg_divider;
   logic [W-1:0]   cfg_phase;
   logic           sync_restart;
   logic [NR-1:0]  enable;

   clock_enable_bank #(
      .NR_OF_CHANNELS_P (NR),
      .COUNTER_WIDTH_P  (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_channel  (cfg_channel),
      .cfg_divider  (cfg_divider),
      .cfg_phase    (cfg_phase),
      .sync_restart (sync_restart),
      .enable       (enable)
   );

   typedef struct {
      int            cyc;
      logic [NR-1:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cyc == k between rising edge k and rising edge k+1
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares enable with the queued expectation for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         n_vec++;
         if (enable !== exp_q[0].vec) begin
            n_err++;
            $display("FAIL pulse@%0d: enable=%b expected=%b", cyc, enable, exp_q[0].vec);
         end
         void'(exp_q.pop_front());
      end else if (enable !== '0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_pulse@%0d: enable=%b expected=%b", cyc, enable, {NR{1'b0}});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s@%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Insert keeping the queue sorted by cycle; same-cycle pulses merge.
   task automatic exp_pulse(input int c, input int ch);
      int   i;
      exp_t e;
      i = 0;
      while (i < exp_q.size() && exp_q[i].cyc < c) i++;
      if (i < exp_q.size() && exp_q[i].cyc == c) begin
         e = exp_q[i];
         e.vec[ch] = 1'b1;
         exp_q[i] = e;
      end else begin
         e.cyc = c;
         e.vec = '0;
         e.vec[ch] = 1'b1;
         exp_q.insert(i, e);
      end
   endtask

   task automatic exp_series(input int first, input int period, input int count, input int ch);
      for (int k = 0; k < count; k++) exp_pulse(first + k * period, ch);
   endtask

   task automatic flush_after(input int c);
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > c) void'(exp_q.pop_back());
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Drives one write for one edge; e0 is the edge that samples it.
   task automatic wr(input int ch, input int div, input int ph, input logic exp_rdy,
                     output int e0);
      cfg_valid   = 1'b1;
      cfg_channel = CHW'(ch);
      cfg_divider = W'(div);
      cfg_phase   = W'(ph);
      #1;
      chk("wr_ready", 32'(cfg_ready), 32'(exp_rdy));
      e0 = cyc + 1;
      $display("cyc %0d: write ch%0d D=%0d phase=%0d", e0, ch, div, ph);
      step(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      int e0, e1, e2, e3, e4, e5, s;
      rst_n        = 1'b0;
      cfg_valid    = 1'b0;
      cfg_channel  = '0;
      cfg_divider  = '0;
      cfg_phase    = '0;
      sync_restart = 1'b0;
      step(3);
      chk("reset_enable", 32'(enable), 32'(0));
      chk("reset_ready", 32'(cfg_ready), 32'(1));
      rst_n = 1'b1;
      step(3);

      // ch0 D=4 from idle: pulses at E0+4/8/12; D=0 written mid-period
      // gives one final pulse at the next wrap (E0+16).
      wr(0, 4, 0, 1'b1, e0);
      exp_series(e0 + 4, 4, 4, 0);
      step(12);
      wr(0, 0, 0, 1'b1, e1);
      cfg_channel = 2'd0;
      #1 chk("ch0_pending_ready", 32'(cfg_ready), 32'(0));
      step(2);
      chk("ch0_pending_ready_late", 32'(cfg_ready), 32'(0));
      step(1);
      chk("ch0_applied_ready", 32'(cfg_ready), 32'(1));
      step(6);

      // ch1 D=10, D=3 written while counter=2: pending until the wrap at
      // E0+10, then every 3 cycles. A write offered while not ready is dropped.
      wr(1, 10, 0, 1'b1, e0);
      exp_pulse(e0 + 10, 1);
      exp_series(e0 + 13, 3, 4, 1);
      step(2);
      wr(1, 3, 0, 1'b1, e1);
      cfg_valid   = 1'b1;
      cfg_channel = 2'd1;
      cfg_divider = 8'd5;
      #1 chk("stall_ready", 32'(cfg_ready), 32'(0));
      step(1);
      cfg_valid   = 1'b0;
      cfg_channel = 2'd0;
      #1 chk("other_ch_ready", 32'(cfg_ready), 32'(1));
      cfg_channel = 2'd1;
      step(5);
      chk("ch1_pending_ready", 32'(cfg_ready), 32'(0));
      step(1);
      chk("ch1_applied_ready", 32'(cfg_ready), 32'(1));
      step(9);
      wr(1, 0, 0, 1'b1, e2);
      step(6);

      // ch0 D=8 ph0, ch1 D=8 ph4, then restart: ch1 leads ch0 by 4.
      wr(0, 8, 0, 1'b1, e0);
      wr(1, 8, 4, 1'b1, e1);
      sync_restart = 1'b1;
      s = cyc + 1;
      step(1);
      sync_restart = 1'b0;
      exp_series(s + 4, 8, 4, 1);
      exp_series(s + 8, 8, 3, 0);
      step(20);
      wr(0, 0, 0, 1'b1, e2);
      wr(1, 0, 0, 1'b1, e3);
      step(10);

      // ch2 D=1: enable held high; D=0 ends it after one more wrap.
      wr(2, 1, 0, 1'b1, e0);
      exp_series(e0 + 1, 1, 7, 2);
      step(5);
      wr(2, 0, 0, 1'b1, e1);
      step(8);

      // ch0 D=5 phase=7 -> restart loads 0; idle ch1 written on the restart
      // edge starts at its phase 3. Out-of-range channel write is dropped.
      wr(0, 5, 7, 1'b1, e0);
      step(1);
      cfg_valid    = 1'b1;
      cfg_channel  = 2'd1;
      cfg_divider  = 8'd6;
      cfg_phase    = 8'd3;
      sync_restart = 1'b1;
      #1 chk("sync_wr_ready", 32'(cfg_ready), 32'(1));
      s = cyc + 1;
      $display("cyc %0d: sync_restart with write ch1 D=6 phase=3", s);
      step(1);
      cfg_valid    = 1'b0;
      sync_restart = 1'b0;
      exp_series(s + 5, 5, 4, 0);
      exp_series(s + 3, 6, 4, 1);
      wr(3, 2, 0, 1'b1, e1);
      step(14);
      wr(0, 0, 0, 1'b1, e2);
      wr(1, 0, 0, 1'b1, e3);
      step(8);

      // Largest divider (2^W-1) on ch2.
      wr(2, 255, 0, 1'b1, e0);
      exp_pulse(e0 + 255, 2);
      step(256);
      // Restart while ch0 runs D=1: no pulse on the restart edge.
      wr(0, 1, 0, 1'b1, e1);
      exp_series(e1 + 1, 1, 4, 0);
      wr(1, 3, 0, 1'b1, e2);
      exp_pulse(e2 + 3, 1);
      step(3);
      sync_restart = 1'b1;
      s = cyc + 1;
      $display("cyc %0d: sync_restart", s);
      step(1);
      sync_restart = 1'b0;
      exp_series(s + 1, 1, 7, 0);
      exp_series(s + 3, 3, 2, 1);
      step(5);
      wr(1, 2, 0, 1'b1, e3);
      cfg_channel = 2'd1;
      #1 chk("pre_reset_pending_ready", 32'(cfg_ready), 32'(0));
      step(1);
      // Reset while ch0 enable is high and ch1 has a pending shadow.
      rst_n = 1'b0;
      $display("cyc %0d: reset asserted", cyc);
      flush_after(cyc);
      #1;
      chk("reset_mid_enable", 32'(enable), 32'(0));
      chk("reset_mid_ready", 32'(cfg_ready), 32'(1));
      step(3);
      rst_n = 1'b1;
      step(20);
      wr(1, 2, 0, 1'b1, e4);
      exp_series(e4 + 2, 2, 3, 1);
      step(3);
      wr(1, 0, 0, 1'b1, e5);
      step(10);

      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
